frame_serializer: RTL and testbench

Parallel-to-serial output stage for the FFT/filter datapath. Accepts one 8-sample frame (in1..in8, the same fan-out the `filter` stage produces as o1..o8) per handshake and emits the samples one per cycle on a valid/ready stream, in1 first. A two-frame buffer (active + pending) keeps the upstream side unstalled while a frame drains.

---
 rtl/fft_pkg.sv | 16 +
 rtl/frame_serializer_if.sv | 25 ++
 rtl/frame_serializer_frame_reg.sv | 30 +++
 rtl/frame_serializer.sv | 107 ++++++++++
 tb/tb_frame_serializer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the FFT/filter output stages.
package fft_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int FRAME_LEN = 8;
  localparam int IDX_W     = 3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/frame_serializer_if.sv
// Frame-in / sample-out bus of the serializer; master is the environment, slave the serializer.
interface frame_serializer_if #(
  parameter int WIDTH = fft_pkg::WIDTH_DEF
);

  logic [WIDTH-1:0]          in1, in2, in3, in4, in5, in6, in7, in8;
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [fft_pkg::IDX_W-1:0] out_idx;
  logic                      out_last;

  modport master (
    output in1, in2, in3, in4, in5, in6, in7, in8, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_idx, out_last
  );

  modport slave (
    input  in1, in2, in3, in4, in5, in6, in7, in8, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_idx, out_last
  );

endinterface

// File: rtl/frame_serializer_frame_reg.sv
// Eight-sample load-enable register bank, cleared by reset so its contents are never X.
module frame_reg
  import fft_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_i,
  input  logic [FRAME_LEN-1:0][WIDTH-1:0] d_i,
  output logic [FRAME_LEN-1:0][WIDTH-1:0] q_o
);

  generate
    for (genvar gi = 0; gi < FRAME_LEN; gi++) begin : g_slot
      logic [WIDTH-1:0] slot_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          slot_q <= '0;
        end else if (load_i) begin
          slot_q <= d_i[gi];
        end
      end

      assign q_o[gi] = slot_q;
    end
  endgenerate

endmodule

// File: rtl/frame_serializer.sv
// Parallel-to-serial output stage: accepts 8-sample frames, emits one sample per beat, in1 first.
// Active frame A drains while a pending frame P waits, so done-beat reloads A with no bubble.
module frame_serializer
  import fft_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  frame_serializer_if.slave  bus
);

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [FRAME_LEN-1:0][WIDTH-1:0] in_frame;
  logic [FRAME_LEN-1:0][WIDTH-1:0] a_q, p_q, a_d;
  logic                            load_a, load_p;
  logic                            in_ready, out_valid;
  logic                            accept, beat, done;

  // Element 0 is in1, so it is the first sample out.
  assign in_frame = {bus.in8, bus.in7, bus.in6, bus.in5,
                     bus.in4, bus.in3, bus.in2, bus.in1};

  assign accept = bus.in_valid && in_ready;
  assign beat   = out_valid && bus.out_ready;
  assign done   = beat && (idx_q == LAST_IDX);

  // A is refilled from P only when draining out of TWO; otherwise from the inputs.
  assign a_d = (state_q == TWO) ? p_q : in_frame;

  frame_reg #(.WIDTH(WIDTH)) u_frame_a (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_a),
    .d_i    (a_d),
    .q_o    (a_q)
  );

  frame_reg #(.WIDTH(WIDTH)) u_frame_p (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_p),
    .d_i    (in_frame),
    .q_o    (p_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load_a  = 1'b0;
    load_p  = 1'b0;
    if (beat) begin
      idx_d = idx_q + 1'b1;
    end
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          load_a  = 1'b1;
          idx_d   = '0;
        end
      end
      ONE: begin
        if (accept && !done) begin
          state_d = TWO;
          load_p  = 1'b1;
        end else if (accept && done) begin
          load_a  = 1'b1;
        end else if (done) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (done) begin
          state_d = ONE;
          load_a  = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    in_ready      = (state_q != TWO);
    out_valid     = (state_q != EMPTY);
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid;
    bus.out_data  = a_q[idx_q];
    bus.out_idx   = idx_q;
    bus.out_last  = out_valid && (idx_q == LAST_IDX);
  end

endmodule

// File: tb/tb_frame_serializer.sv
// Randomised and directed bench for frame_serializer, checked against a sample-queue model.
module tb_frame_serializer;

  logic clk;
  logic rst;

  frame_serializer_if #(.WIDTH(8)) bus ();

  frame_serializer #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: every sample still owed downstream, in emission order.
  logic [7:0] mq[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else begin
      logic m_acc;
      logic m_beat;
      m_acc  = bus.in_valid && (mq.size() <= 8);
      m_beat = (mq.size() > 0) && bus.out_ready;
      if (m_beat) void'(mq.pop_front());
      if (m_acc) begin
        mq.push_back(bus.in1); mq.push_back(bus.in2);
        mq.push_back(bus.in3); mq.push_back(bus.in4);
        mq.push_back(bus.in5); mq.push_back(bus.in6);
        mq.push_back(bus.in7); mq.push_back(bus.in8);
      end
    end
  end

  always @(negedge clk) begin
    int n;
    int e_idx;
    n     = mq.size();
    e_idx = (8 - (n % 8)) % 8;
    chk("m_in_ready", bus.in_ready, n <= 8);
    chk("m_out_valid", bus.out_valid, n > 0);
    chk("m_out_last", bus.out_last, (n > 0) && (e_idx == 7));
    if (n > 0) begin
      chk("m_out_data", bus.out_data, mq[0]);
      chk("m_out_idx", bus.out_idx, e_idx);
    end
    if (rst) chk("m_rst_data", bus.out_data, 0);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_frame(input logic [7:0][7:0] f);
    bus.in1 = f[0]; bus.in2 = f[1]; bus.in3 = f[2]; bus.in4 = f[3];
    bus.in5 = f[4]; bus.in6 = f[5]; bus.in7 = f[6]; bus.in8 = f[7];
  endtask

  function automatic logic [7:0][7:0] ramp(input logic [7:0] base, input logic [7:0] inc);
    logic [7:0][7:0] f;
    for (int i = 0; i < 8; i++) f[i] = 8'(base + inc * i);
    return f;
  endfunction

  task automatic send(input logic [7:0][7:0] f);
    logic r;
    logic ok;
    ok = 1'b0;
    set_frame(f);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 40 && !ok; c++) begin
      r = bus.in_ready;
      step();
      ok = r;
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && !ok; c++) begin
      if (!bus.out_valid) ok = 1'b1;
      else step();
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    logic r;
    logic ok;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_frame('0);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_idx", bus.out_idx, 0);
    chk("rst_out_last", bus.out_last, 0);
    rst = 1'b0;
    step();

    // Single frame 0x11..0x88, first sample one cycle after accept
    bus.out_ready = 1'b1;
    send(ramp(8'h11, 8'h11));
    for (int b = 0; b < 8; b++) begin
      chk("single_data", bus.out_data, 8'(8'h11 * (b + 1)));
      chk("single_idx", bus.out_idx, b);
      chk("single_last", bus.out_last, b == 7);
      step();
    end
    chk("single_after_valid", bus.out_valid, 0);

    // Backpressure: out_ready 1,0,0,1,0,0,...
    set_frame(ramp(8'h31, 8'h01));
    bus.in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      bus.out_ready = (c % 3 == 0);
      r = bus.in_ready;
      step();
      if (r) bus.in_valid = 1'b0;
    end
    chk("bp_drained", bus.out_valid, 0);
    drain();

    // Back-to-back: second frame lands in P, no bubble between 0x17 and 0x20
    send(ramp(8'h10, 8'h01));
    set_frame(ramp(8'h20, 8'h01));
    bus.in_valid = 1'b1;
    chk("b2b_ready_one", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    chk("b2b_ready_two", bus.in_ready, 0);
    chk("b2b_data1", bus.out_data, 8'h11);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      if (bus.out_data == 8'h17) ok = 1'b1;
      else step();
    end
    chk("b2b_reach17", ok, 1);
    chk("b2b_ready_at17", bus.in_ready, 0);
    step();
    chk("b2b_nobubble", bus.out_data, 8'h20);
    chk("b2b_idx0", bus.out_idx, 0);
    chk("b2b_ready_after", bus.in_ready, 1);
    drain();

    // Accept on the exact done beat of 0x88
    send(ramp(8'h11, 8'h11));
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      if (bus.out_idx == 3'd7) ok = 1'b1;
      else step();
    end
    chk("sim_reach_last", ok, 1);
    chk("sim_last_data", bus.out_data, 8'h88);
    set_frame(ramp(8'h51, 8'h01));
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("sim_data", bus.out_data, 8'h51);
    chk("sim_idx", bus.out_idx, 0);
    chk("sim_valid", bus.out_valid, 1);
    chk("sim_ready_one", bus.in_ready, 1);
    drain();

    // Randomised traffic
    for (int c = 0; c < 600; c++) begin
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      set_frame({$urandom(), $urandom()});
      step();
    end
    bus.in_valid = 1'b0;
    drain();

    // Reset after the third beat with P full
    send(ramp(8'h60, 8'h01));
    set_frame(ramp(8'h70, 8'h01));
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    chk("mid_data3", bus.out_data, 8'h63);
    chk("mid_p_full", bus.in_ready, 0);
    #1 rst = 1'b1;
    #1;
    chk("async_out_valid", bus.out_valid, 0);
    chk("async_in_ready", bus.in_ready, 1);
    chk("async_out_data", bus.out_data, 0);
    chk("async_out_idx", bus.out_idx, 0);
    chk("async_out_last", bus.out_last, 0);
    step();
    rst = 1'b0;
    step();
    bus.out_ready = 1'b1;
    send(ramp(8'hA0, 8'h01));
    chk("post_rst_data", bus.out_data, 8'hA0);
    chk("post_rst_idx", bus.out_idx, 0);
    drain();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
